pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the Keep/Reset controls of PC, IF_ID, ID_Ex, Ex_Mem.
//  Detects load-use hazards in ID and flushes on taken branch/jump resolved in Mem.
//  Sequences multi-cycle mul/div ops held in ID via a start/done handshake with timeout.
// PARAMETERS
//  REG_AW         5   register address width
//  MD_MAX_CYCLES  64  max BUSY cycles before timeout release (>=2)
//  CNT_W          32  perf counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk          in   1      rising-edge clock
//  Reset        in   1      synchronous, active-high
//  Rs_ID        in   REG_AW source reg A of instruction in ID
//  Rt_ID        in   REG_AW source reg B of instruction in ID
//  UseRt_ID     in   1      ID instruction reads Rt
//  MemRead_Ex   in   1      Ex instruction is a load
//  RegWr_Ex     in   1      Ex instruction writes a register
//  Rd_Ex        in   REG_AW destination reg of Ex instruction
//  MdOp_ID      in   1      ID instruction is multi-cycle mul/div
//  md_done      in   1      mul/div unit finished (1-cycle pulse)
//  Redirect_Mem in   1      PCSource!=0 in Mem (branch taken or jump)
//  Keep_PC      out  1      hold PC
//  Keep_IF_ID   out  1      hold IF_ID
//  Reset_IF_ID  out  1      flush IF_ID
//  Reset_ID_Ex  out  1      insert bubble into ID_Ex
//  Reset_Ex_Mem out  1      flush Ex_Mem
//  md_start     out  1      start pulse to mul/div unit
//  md_abort     out  1      cancel in-flight mul/div
//  md_timeout   out  1      sticky error flag, cleared only by Reset
//  stall_cnt    out  CNT_W  stall cycles (perf)
//  flush_cnt    out  CNT_W  redirect events (perf)
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, md_timeout=0, counters=0; all outputs 0 while Reset=1.
//  Outputs are combinational from state + inputs; the next state and counters are registered.
//  Load-use: lu = MemRead_Ex & RegWr_Ex & Rd_Ex!=0 & (Rd_Ex==Rs_ID | (UseRt_ID & Rd_Ex==Rt_ID)).
//   lu -> Keep_PC=Keep_IF_ID=Reset_ID_Ex=1 for that cycle. This gives exactly a 1-cycle bubble.
//  MD FSM states: IDLE, BUSY, DONE.
//   IDLE & MdOp_ID: md_start=1 and stall this cycle; -> BUSY, timer=0.
//   BUSY: stall every cycle; timer++. md_done -> DONE. timer==MD_MAX_CYCLES-1 without done -> md_timeout=1, md_abort=1, -> DONE.
//   DONE: no MD stall, so the op advances to Ex; -> IDLE. A new MdOp_ID seen in IDLE afterwards starts again.
//   md_done outside BUSY is ignored.
//  "stall" = Keep_PC=Keep_IF_ID=Reset_ID_Ex=1. MD stall and load-use stall OR together.
//  Redirect_Mem has the highest priority:
//   Reset_IF_ID=Reset_ID_Ex=Reset_Ex_Mem=1 and Keep_PC=Keep_IF_ID=0 (PC loads target).
//   md_start is suppressed. In BUSY: md_abort=1 and the next state is IDLE. In DONE: the next state is IDLE.
//   Load-use is ignored in the same cycle.
//  Reset asserted mid-BUSY -> IDLE next edge, no md_abort pulse.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   stall_cnt += 1 per cycle with Keep_PC=1 and no redirect.
//   flush_cnt += 1 per Redirect_Mem cycle.
//   Both counters saturate at all-ones and reset to 0.
//  HAZ_PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.
// TESTING
//  1. Rd_Ex=5, MemRead_Ex=1, RegWr_Ex=1, Rs_ID=5 -> one cycle Keep_PC=Keep_IF_ID=Reset_ID_Ex=1. Same with Rd_Ex=0 -> no stall.
//  2. Rt_ID=7 matches Rd_Ex=7 with UseRt_ID=0 -> no stall. With UseRt_ID=1 -> 1-cycle stall.
//  3. MdOp_ID=1, md_done 4 cycles after md_start -> md_start one cycle, 5 stall cycles total, DONE cycle unstalled, then IDLE.
//  4. MdOp_ID=1, md_done never, MD_MAX_CYCLES=8 -> md_timeout=1 and md_abort pulse after 8 BUSY cycles. Flag stays 1 until Reset.
//  5. Redirect_Mem=1 during BUSY with lu=1 -> all three flushes, Keep_PC=0, md_abort=1, IDLE next cycle.
//  6. HAZ_PERF_CNT_EN defined: 3 load-use stalls + 2 redirects -> stall_cnt=3, flush_cnt=2. Undefined -> both read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline: load-use
//               bubbles, Mem-stage redirect flushes and mul/div start/done
//               sequencing with timeout. Optional perf counters are enabled
//               by defining HAZ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_AW        = 5,
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic              UseRt_ID,
    input  logic              MemRead_Ex,
    input  logic              RegWr_Ex,
    input  logic [REG_AW-1:0] Rd_Ex,
    input  logic              MdOp_ID,
    input  logic              md_done,
    input  logic              Redirect_Mem,
    output logic              Keep_PC,
    output logic              Keep_IF_ID,
    output logic              Reset_IF_ID,
    output logic              Reset_ID_Ex,
    output logic              Reset_Ex_Mem,
    output logic              md_start,
    output logic              md_abort,
    output logic              md_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                  c_TMR_W    = $clog2(MD_MAX_CYCLES);
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(MD_MAX_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE  = c_TMR_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_timeout;

    logic               w_lu;
    logic               w_idle;
    logic               w_busy;
    logic               w_tmo_hit;
    logic               w_stall;
    logic [1:0]         w_next_state;
    logic [c_TMR_W-1:0] w_next_timer;
    logic               w_set_tmo;

    always_comb begin
        w_lu      = MemRead_Ex & RegWr_Ex & (Rd_Ex != '0) &
                    ((Rd_Ex == Rs_ID) | (UseRt_ID & (Rd_Ex == Rt_ID)));
        w_idle    = (r_state == c_ST_IDLE);
        w_busy    = (r_state == c_ST_BUSY);
        // A done arriving on the last allowed cycle still counts as success.
        w_tmo_hit = w_busy & ~md_done & (r_timer == c_TMR_LAST);
        w_stall   = w_lu | (w_idle & MdOp_ID) | w_busy;
    end

    always_comb begin
        Keep_PC      = 1'b0;
        Keep_IF_ID   = 1'b0;
        Reset_IF_ID  = 1'b0;
        Reset_ID_Ex  = 1'b0;
        Reset_Ex_Mem = 1'b0;
        md_start     = 1'b0;
        md_abort     = 1'b0;
        if (!Reset) begin
            if (Redirect_Mem) begin
                Reset_IF_ID  = 1'b1;
                Reset_ID_Ex  = 1'b1;
                Reset_Ex_Mem = 1'b1;
                md_abort     = w_busy;
            end else begin
                Keep_PC      = w_stall;
                Keep_IF_ID   = w_stall;
                Reset_ID_Ex  = w_stall;
                md_start     = w_idle & MdOp_ID;
                md_abort     = w_tmo_hit;
            end
        end
    end

    assign md_timeout = r_timeout & ~Reset;

    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_set_tmo    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (MdOp_ID && !Redirect_Mem) begin
                    w_next_state = c_ST_BUSY;
                    w_next_timer = '0;
                end
            end
            c_ST_BUSY: begin
                if (Redirect_Mem) begin
                    w_next_state = c_ST_IDLE;
                end else if (md_done) begin
                    w_next_state = c_ST_DONE;
                end else if (w_tmo_hit) begin
                    w_next_state = c_ST_DONE;
                    w_set_tmo    = 1'b1;
                end else begin
                    w_next_timer = r_timer + c_TMR_ONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= c_ST_IDLE;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_timeout <= r_timeout | w_set_tmo;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Keep_PC is already forced low on redirect cycles, so it is the stall qualifier.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (Keep_PC && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (Redirect_Mem && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = Reset ? '0 : r_stall_cnt;
    assign flush_cnt = Reset ? '0 : r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int MAXC   = 8;
    localparam int CNT_W  = 32;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              Reset;
    logic [REG_AW-1:0] Rs_ID, Rt_ID, Rd_Ex;
    logic              UseRt_ID, MemRead_Ex, RegWr_Ex, MdOp_ID, md_done, Redirect_Mem;
    logic              Keep_PC, Keep_IF_ID, Reset_IF_ID, Reset_ID_Ex, Reset_Ex_Mem;
    logic              md_start, md_abort, md_timeout;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic [7:0]        obs;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: MD phase (0 idle, 1 waiting on unit, 2 handing off),
    // cycles spent waiting, sticky timeout, perf tallies.
    int     m_phase = 0;
    int     m_wait  = 0;
    bit     m_tmo   = 1'b0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW        (REG_AW),
        .MD_MAX_CYCLES (MAXC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .UseRt_ID     (UseRt_ID),
        .MemRead_Ex   (MemRead_Ex),
        .RegWr_Ex     (RegWr_Ex),
        .Rd_Ex        (Rd_Ex),
        .MdOp_ID      (MdOp_ID),
        .md_done      (md_done),
        .Redirect_Mem (Redirect_Mem),
        .Keep_PC      (Keep_PC),
        .Keep_IF_ID   (Keep_IF_ID),
        .Reset_IF_ID  (Reset_IF_ID),
        .Reset_ID_Ex  (Reset_ID_Ex),
        .Reset_Ex_Mem (Reset_Ex_Mem),
        .md_start     (md_start),
        .md_abort     (md_abort),
        .md_timeout   (md_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Order: Keep_PC Keep_IF_ID Reset_IF_ID Reset_ID_Ex Reset_Ex_Mem md_start md_abort md_timeout
    assign obs = {Keep_PC, Keep_IF_ID, Reset_IF_ID, Reset_ID_Ex, Reset_Ex_Mem,
                  md_start, md_abort, md_timeout};

    function automatic logic [7:0] model_out();
        bit lu, st;
        if (Reset) return 8'h00;
        if (Redirect_Mem) return {5'b00111, 1'b0, (m_phase == 1), m_tmo};
        lu = MemRead_Ex && RegWr_Ex && (Rd_Ex != 0) &&
             ((Rd_Ex == Rs_ID) || (UseRt_ID && (Rd_Ex == Rt_ID)));
        st = lu || (m_phase == 1) || (m_phase == 0 && MdOp_ID);
        return {st, st, 1'b0, st, 1'b0, (m_phase == 0 && MdOp_ID),
                (m_phase == 1 && !md_done && m_wait == MAXC - 1), m_tmo};
    endfunction

    task automatic model_step();
        logic [7:0] o;
        if (Reset) begin
            m_phase = 0; m_wait = 0; m_tmo = 1'b0; m_stall = 0; m_flush = 0;
            return;
        end
        o = model_out();
        if (o[7] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (Redirect_Mem && m_flush < 64'hFFFF_FFFF) m_flush++;
        if (m_phase == 0) begin
            if (MdOp_ID && !Redirect_Mem) begin m_phase = 1; m_wait = 0; end
        end else if (m_phase == 1) begin
            if (Redirect_Mem) m_phase = 0;
            else if (md_done) m_phase = 2;
            else if (m_wait == MAXC - 1) begin m_phase = 2; m_tmo = 1'b1; end
            else m_wait++;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic next_cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        Rs_ID = '0; Rt_ID = '0; Rd_Ex = '0; UseRt_ID = 0; MemRead_Ex = 0;
        RegWr_Ex = 0; MdOp_ID = 0; md_done = 0; Redirect_Mem = 0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            Reset = (c < 2);
            if (c < 2) begin
                MdOp_ID = 1; Redirect_Mem = 1; MemRead_Ex = 1; RegWr_Ex = 1;
                Rd_Ex = 5'd3; Rs_ID = 5'd3;
            end else begin
                clear_inputs();
            end
            #1;
            n_cmp++;
            if (obs !== 8'h00 || stall_cnt !== '0 || flush_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset c%0d: outs=%b st=%0d fl=%0d want 00000000/0/0",
                         c, obs, stall_cnt, flush_cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use_rs();
        logic [7:0] exp;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin MemRead_Ex = 1; RegWr_Ex = 1; Rd_Ex = 5'd5; Rs_ID = 5'd5; exp = 8'b1101_0000; end
                1: begin Rd_Ex = 5'd5; Rs_ID = 5'd5; exp = 8'h00; end
                2: begin MemRead_Ex = 1; RegWr_Ex = 1; Rd_Ex = 5'd0; Rs_ID = 5'd0; exp = 8'h00; end
                default: begin MemRead_Ex = 1; Rd_Ex = 5'd5; Rs_ID = 5'd5; exp = 8'h00; end
            endcase
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL load_use_rs c%0d: outs=%b want %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use_rt();
        logic [7:0] exp;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            MemRead_Ex = (c < 2); RegWr_Ex = (c < 2);
            Rd_Ex = 5'd7; Rt_ID = 5'd7; Rs_ID = 5'd3;
            UseRt_ID = (c == 1);
            exp = (c == 1) ? 8'b1101_0000 : 8'h00;
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL load_use_rt c%0d: outs=%b want %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_md_done();
        logic [7:0] exp;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            MdOp_ID = (c <= 5);
            md_done = (c == 4) || (c == 7);
            if (c == 0) exp = 8'b1101_0100;
            else if (c <= 4) exp = 8'b1101_0000;
            else exp = 8'h00;
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL md_done c%0d: outs=%b want %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_md_timeout();
        logic [7:0] exp;
        for (int c = 0; c < 15; c++) begin
            clear_inputs();
            MdOp_ID = (c <= 8);
            Reset   = (c == 13);
            if (c == 0) exp = 8'b1101_0100;
            else if (c <= 7) exp = 8'b1101_0000;
            else if (c == 8) exp = 8'b1101_0010;
            else if (c <= 12) exp = 8'b0000_0001;
            else exp = 8'h00;
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL md_timeout c%0d: outs=%b want %b", c, obs, exp);
            end
            next_cycle();
        end
        Reset = 0;
    endtask

    task automatic test_redirect();
        logic [7:0] exp;
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            case (c)
                0: begin MdOp_ID = 1; exp = 8'b1101_0100; end
                1: begin MdOp_ID = 1; Redirect_Mem = 1; MemRead_Ex = 1; RegWr_Ex = 1;
                         Rd_Ex = 5'd4; Rs_ID = 5'd4; exp = 8'b0011_1010; end
                2: exp = 8'h00;
                3: begin MdOp_ID = 1; exp = 8'b1101_0100; end
                4: begin MdOp_ID = 1; md_done = 1; exp = 8'b1101_0000; end
                5: begin MdOp_ID = 1; Redirect_Mem = 1; exp = 8'b0011_1000; end
                6: begin MdOp_ID = 1; exp = 8'b1101_0100; end
                7: begin Redirect_Mem = 1; exp = 8'b0011_1010; end
                default: exp = 8'h00;
            endcase
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL redirect c%0d: outs=%b want %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] exp_st, exp_fl;
        clear_inputs();
        Reset = 1;
        next_cycle();
        Reset = 0;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            if (c == 0 || c == 2 || c == 4) begin
                MemRead_Ex = 1; RegWr_Ex = 1; Rd_Ex = 5'd9; Rs_ID = 5'd9;
            end
            Redirect_Mem = (c == 3 || c == 5);
            #1;
            if (c == 7) begin
                exp_st = PERF ? 32'd3 : 32'd0;
                exp_fl = PERF ? 32'd2 : 32'd0;
                n_cmp++;
                if (stall_cnt !== exp_st || flush_cnt !== exp_fl) begin
                    n_fail++;
                    $display("FAIL perf: stall_cnt=%0d flush_cnt=%0d want %0d/%0d",
                             stall_cnt, flush_cnt, exp_st, exp_fl);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [7:0]       exp;
        logic [CNT_W-1:0] exp_st, exp_fl;
        Reset = 1;
        clear_inputs();
        next_cycle();
        for (int c = 0; c < 3000; c++) begin
            Reset        = ($urandom_range(0, 63) == 0);
            Rs_ID        = REG_AW'($urandom_range(0, 7));
            Rt_ID        = REG_AW'($urandom_range(0, 7));
            Rd_Ex        = REG_AW'($urandom_range(0, 7));
            UseRt_ID     = 1'($urandom_range(0, 1));
            MemRead_Ex   = 1'($urandom_range(0, 1));
            RegWr_Ex     = ($urandom_range(0, 3) != 0);
            MdOp_ID      = ($urandom_range(0, 2) == 0);
            md_done      = ($urandom_range(0, 9) == 0);
            Redirect_Mem = ($urandom_range(0, 15) == 0);
            #1;
            exp    = model_out();
            exp_st = (PERF && !Reset) ? CNT_W'(m_stall) : '0;
            exp_fl = (PERF && !Reset) ? CNT_W'(m_flush) : '0;
            n_cmp++;
            if (obs !== exp || stall_cnt !== exp_st || flush_cnt !== exp_fl) begin
                n_fail++;
                $display("FAIL random c%0d: outs=%b st=%0d fl=%0d want %b st=%0d fl=%0d",
                         c, obs, stall_cnt, flush_cnt, exp, exp_st, exp_fl);
            end
            next_cycle();
        end
    endtask

    initial begin
        Reset = 1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_load_use_rs();
        test_load_use_rt();
        test_md_done();
        test_md_timeout();
        test_redirect();
        test_perf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
